// File: rtl/alu_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient on Q (LO), remainder on R (HI).
// One quotient bit per cycle, with a sign-fix cycle at the end and a shortcut for divide-by-zero.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] raw_a;
    logic             neg_a;
    logic             neg_q;
    logic             zero_op;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // quo starts as the dividend magnitude and fills with quotient bits as the dividend shifts out
    assign a_mag   = (Sign && A[WIDTH-1]) ? -A : A;
    assign b_mag   = (Sign && B[WIDTH-1]) ? -B : B;
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, div_mag};
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (B == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            div_mag <= '0;
            raw_a   <= '0;
            neg_a   <= 1'b0;
            neg_q   <= 1'b0;
            zero_op <= 1'b0;
            Q       <= '0;
            R       <= '0;
            DivZero <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_a   <= Sign & A[WIDTH-1];
                        neg_q   <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                        quo     <= a_mag;
                        div_mag <= b_mag;
                        rem     <= '0;
                        count   <= CW'(WIDTH - 1);
                        raw_a   <= A;
                        zero_op <= (B == '0);
                    end
                end
                RUN: begin
                    // A set borrow bit means the trial went negative: restore and shift in 0
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                    end
                    quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    count <= count - 1'b1;
                end
                FIX: begin
                    if (zero_op) begin
                        Q       <= '1;
                        R       <= raw_a;
                        DivZero <= 1'b1;
                    end else begin
                        Q       <= neg_q ? -quo : quo;
                        R       <= neg_a ? -rem : rem;
                        DivZero <= 1'b0;
                    end
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// Directed self-checking bench for alu_divider: latency, signed/unsigned results,
// divide-by-zero, ignored start while busy, and asynchronous reset mid-operation.
module tb_alu_divider;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         Sign;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         DivZero;

    int testsRun;
    int testsFailed;

    alu_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Sign    (Sign),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Q       (Q),
        .R       (R),
        .DivZero (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives operands with start high across exactly one rising edge (edge k), returns #1 after it.
    task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        Sign  = s;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one division, optionally pulsing a second start after edge k+injectAt, and checks
    // latency, busy during the operation, results, and that done lasts a single cycle.
    task automatic runDivision(input string name, input logic s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int expLat, input logic [W-1:0] expQ,
                               input logic [W-1:0] expR, input logic expDz, input int injectAt);
        int   cycles;
        logic busyOk;
        applyStimulus(s, a, b);
        checkOutput({name, " busy after start"}, W'(busy), W'(1));
        cycles = 0;
        busyOk = 1'b1;
        while (cycles < 60) begin
            if (injectAt > 0 && cycles == injectAt - 1) begin
                Sign  = ~s;
                A     = 32'd50;
                B     = 32'd5;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            if (done) break;
            if (!busy) busyOk = 1'b0;
        end
        checkOutput({name, " latency"}, W'(cycles), W'(expLat));
        checkOutput({name, " busy held"}, W'(busyOk), W'(1));
        checkOutput({name, " busy low at done"}, W'(busy), W'(0));
        checkOutput({name, " Q"}, Q, expQ);
        checkOutput({name, " R"}, R, expR);
        checkOutput({name, " DivZero"}, W'(DivZero), W'(expDz));
        @(posedge clk);
        #1;
        checkOutput({name, " done one cycle"}, W'(done), W'(0));
        checkOutput({name, " Q held"}, Q, expQ);
    endtask

    initial begin
        int sawDone;
        testsRun    = 0;
        testsFailed = 0;
        start = 1'b0;
        Sign  = 1'b0;
        A     = '0;
        B     = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", W'(busy), W'(0));
        checkOutput("reset done", W'(done), W'(0));
        checkOutput("reset Q", Q, '0);
        checkOutput("reset R", R, '0);
        checkOutput("reset DivZero", W'(DivZero), W'(0));
        @(negedge clk);
        reset = 1'b0;

        runDivision("udiv 100/7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 0);
        runDivision("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
        runDivision("sdiv overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0, 1'b0, 0);
        runDivision("udiv same bits", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0, 0);
        runDivision("div by zero", 1'b0, 32'h1234_5678, 32'h0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
        runDivision("udiv 9/3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0, 0);
        runDivision("start ignored", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 5);

        // Reset in the middle of a division: everything clears at once and no done follows.
        applyStimulus(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("midrun reset busy", W'(busy), W'(0));
        checkOutput("midrun reset done", W'(done), W'(0));
        checkOutput("midrun reset Q", Q, '0);
        checkOutput("midrun reset R", R, '0);
        checkOutput("midrun reset DivZero", W'(DivZero), W'(0));
        @(negedge clk);
        reset = 1'b0;
        sawDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) sawDone++;
        end
        checkOutput("no done after reset", W'(sawDone), W'(0));

        runDivision("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_divider.md
# alu_divider

Multi-cycle 32-bit integer divider that services MIPS DIV/DIVU. It is the sequential counterpart to the combinational add/subtract path and reuses the same `Sign` convention: 1 selects two's-complement, 0 selects unsigned. The block sits beside the ALU in the execute stage. It accepts operands with a start pulse and produces quotient (LO) and remainder (HI) after a fixed latency, signalled by a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; the cycle counts below assume 32.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to begin a division; sampled only in IDLE.
- `Sign`  input  1  1 = signed division, 0 = unsigned; sampled with `start`.
- `A`  input  WIDTH  dividend; sampled with `start`.
- `B`  input  WIDTH  divisor; sampled with `start`.
- `busy`  output  1  operation in progress.
- `done`  output  1  one-cycle pulse; `Q`, `R` and `DivZero` are valid from this cycle.
- `Q`  output  WIDTH  quotient, the LO value.
- `R`  output  WIDTH  remainder, the HI value.
- `DivZero`  output  1  the last operation had `B == 0`.

## Operation
- States: IDLE, RUN, FIX.
- IDLE → RUN on `start`:
  - latch `Sign`, the sign of `A`, and the sign of `A` XOR the sign of `B`;
  - latch magnitudes: `|A|`, `|B|` when `Sign=1`, otherwise raw `A`, `B`;
  - clear the partial remainder; set the iteration counter to 31.
- IDLE → FIX on `start` with `B == 0`. No iterations run.
- RUN: restoring division, one quotient bit per cycle, MSB first.
  - Shift the partial remainder left one bit, bringing in the next dividend bit.
  - Compute a trial subtraction with WIDTH+1 bits.
  - If it is non-negative, keep the difference and set the quotient bit to 1; otherwise keep the shifted value and set the bit to 0.
  - After the counter reaches 0, go to FIX.
- FIX, normal case:
  - negate the quotient if the latched signs differ;
  - negate the remainder if the dividend was negative;
  - write `Q` and `R`, clear `DivZero`, pulse `done`, return to IDLE.
- FIX, divide-by-zero: `Q = {WIDTH{1'b1}}`, `R` = the original raw `A`, `DivZero = 1`, pulse `done`, return to IDLE.
- Signed results truncate toward zero; the remainder takes the sign of the dividend.
- Overflow case `0x80000000 / -1` (signed):
  - the magnitude 2^31 fits unsigned, and negation gives `Q = 0x80000000`, `R = 0`;
  - no special detection is performed.
- `start` while `busy` is ignored; the operation in flight is unaffected.
- `Q`, `R` and `DivZero` hold their values until the next FIX; they do not change during RUN.
- `reset` at any time:
  - return to IDLE;
  - `busy = 0`, `done = 0`, `Q = 0`, `R = 0`, `DivZero = 0`;
  - discard the operation in flight.

## Timing
- Let `start` be sampled at edge k.
- `busy` = 1 after edge k. It stays 1 through the RUN cycles and deasserts at the same edge that asserts `done`.
- Normal division:
  - RUN occupies edges k+1 .. k+32;
  - FIX completes at edge k+33, so `done` = 1 and results are valid after edge k+33;
  - `done` = 0 after edge k+34.
- Divide-by-zero: `done` and results after edge k+1; `busy` = 1 only for the cycle between edges k and k+1.
- A new `start` is accepted in the cycle `done` is high (state is IDLE), giving back-to-back throughput of one result per 34 cycles.
- `done` is never high for more than one cycle. `busy` and `done` are never high together.

## Test plan
- Unsigned division:
  - Stimulus: `Sign=0`, `A=100`, `B=7`, start at edge k.
  - Response: `busy` high k+1..k+33; `done` only after k+33; `Q=14`, `R=2`, `DivZero=0`.
- Signed division:
  - Stimulus: `Sign=1`, `A=-7` (`0xFFFFFFF9`), `B=2`.
  - Response: `Q=0xFFFFFFFD` (-3), `R=0xFFFFFFFF` (-1).
- Signed overflow:
  - Stimulus: `Sign=1`, `A=0x80000000`, `B=0xFFFFFFFF`.
  - Response: `Q=0x80000000`, `R=0`.
- Unsigned with the same bit patterns:
  - Stimulus: `Sign=0`, same operands.
  - Response: `Q=0`, `R=0x80000000`.
- Divide-by-zero:
  - Stimulus: `A=0x12345678`, `B=0`.
  - Response: `done` after edge k+1; `Q=0xFFFFFFFF`, `R=0x12345678`, `DivZero=1`.
  - Follow-up: a later `A=9`, `B=3` clears `DivZero` and gives `Q=3`, `R=0`.
- Control robustness:
  - Stimulus: pulse `start` with different operands at k+5; assert `reset` at k+10 of a second division.
  - Response to the extra start: ignored, and the first result is unchanged.
  - Response to reset: `busy`, `done`, `Q`, `R` and `DivZero` all 0 immediately; no `done` pulse follows; the next start completes normally.
